uart_tx_fifo: RTL

Byte-oriented UART transmitter with a 4-entry input FIFO. It sits downstream of the user project logic inside the top-level `tt_um_*` wrapper and drives one dedicated output pin (a `uo_out` bit) as the serial TX line. The project core pushes bytes through a valid/ready handshake. The block serialises them as 8N1 frames, or 8E1 when parity is compiled in, at a fixed divided bit rate.

---
 rtl/uart_tx_fifo.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a small power-of-two FIFO.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   level,
    output logic [2:0]         state_dbg
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]      LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]      ONE_C    = CW'(1);
    localparam logic [FIFO_AW:0]   FULL_LVL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   ONE_L    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] ONE_P    = FIFO_AW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level_next;
    logic               full;
    logic               push;
    logic               pop;
    logic [CW-1:0]      cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
`ifdef UART_TX_PARITY_EN
    logic               parity;
`endif

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // the producer holds in_data stable until that edge, nothing is dropped.
    assign full      = (level == FULL_LVL);
    assign in_ready  = !full && !rst;
    assign push      = in_valid && in_ready;
    assign pop       = (state == ST_IDLE) && (level != '0);
    assign state_dbg = state;

    always_comb begin
        level_next = level;
        if (push && !pop)
            level_next = level + ONE_L;
        else if (pop && !push)
            level_next = level - ONE_L;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ONE_P;
            if (pop)
                rd_ptr <= rd_ptr + ONE_P;
            level <= level_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (pop) begin
                        shift  <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity <= ^mem[rd_ptr];
`endif
                        tx     <= 1'b0;
                        busy   <= 1'b1;
                        state  <= ST_START;
                    end else begin
                        tx   <= 1'b1;
                        busy <= (level_next != '0);
                    end
                end
                ST_START: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        tx    <= shift[0];
                        state <= ST_DATA;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end
                ST_DATA: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            tx    <= parity;
                            state <= ST_PARITY;
`else
                            tx    <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            // shift[1] is the bit that lands in shift[0] at this edge
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= ST_STOP;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        busy  <= (level_next != '0);
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
